// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter_checker slice.
//   state_t   : checker FSM state encoding (IDLE / ACQ / LOCKED)
//   COUNTER_W : default width of the monitored counter value
//   inc_wrap  : modulo-2^W increment helper used for the expected value
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int COUNTER_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Increment that wraps naturally at the vector width (0xFF + 1 = 0x00).
    function automatic logic [COUNTER_W-1:0] inc_wrap(input logic [COUNTER_W-1:0] v);
        return v + COUNTER_W'(1);
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// -----------------------------------------------------------------------------
// counter_checker_if
// Bundles the sampled counter stream and the checker status outputs.
//   ivalue     : counter value under check           (master -> slave)
//   ivalid     : ivalue is a sample this cycle       (master -> slave)
//   olocked    : checker is locked on the stream     (slave -> master)
//   oerror     : one-cycle sequence-break pulse      (slave -> master)
//   orestart   : one-cycle tolerated-restart pulse   (slave -> master)
//   oerr_count : saturating error tally              (slave -> master)
//   oexpected  : next value the checker expects      (slave -> master)
// master = stream source / observer, slave = counter_checker.
// -----------------------------------------------------------------------------
interface counter_checker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] ivalue;
    logic             ivalid;
    logic             olocked;
    logic             oerror;
    logic             orestart;
    logic [ERR_W-1:0] oerr_count;
    logic [WIDTH-1:0] oexpected;

    modport master (
        output ivalue, ivalid,
        input  olocked, oerror, orestart, oerr_count, oexpected
    );

    modport slave (
        input  ivalue, ivalid,
        output olocked, oerror, orestart, oerr_count, oexpected
    );
endinterface

// File: rtl/counter_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Parameterised saturating up-counter with enable and asynchronous active-low
// clear. Counts i_en pulses and sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_clr_n : asynchronous active-low clear
//   i_en    : increment request for this cycle
//   o_count : current (registered) count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
// Receive-side monitor for a free-running counter stream. Every valid sample
// must equal the previous one plus 1 (mod 2^WIDTH). The checker acquires lock
// after LOCK_CNT consecutive correct increments, flags sequence breaks while
// locked and keeps a saturating tally of them. All outputs are registered
// (1-cycle latency from the sampling edge).
//
// Ports:
//   iclk   : clock, rising edge
//   ireset : asynchronous active-low reset
//   bus    : counter_checker_if.slave (ivalue/ivalid in; olocked, oerror,
//            orestart, oerr_count, oexpected out)
//
// Parameters: WIDTH (value width), LOCK_CNT (1..15), ERR_W (tally width).
//
// Optional build macro COUNTER_CHECKER_RESTART_EN: when defined, a mismatch
// with ivalue == 0 while locked is taken as a legal counter restart
// (orestart pulse, stays locked, expected = 1). When undefined, orestart is
// constantly 0 and such samples are ordinary errors.
// -----------------------------------------------------------------------------
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH    = COUNTER_W,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             iclk,
    input  logic             ireset,
    counter_checker_if.slave bus
);
    localparam logic [3:0] LOCK_TARGET = LOCK_CNT[3:0];

    state_t           r_state;
    logic [WIDTH-1:0] r_expected;
    logic [3:0]       r_match_cnt;
    logic             r_error;
    logic             r_restart;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_expected_next;
    logic [3:0]       w_match_next;
    logic             w_error_next;
    logic             w_restart_next;
    logic             w_hit;
    logic             w_restart_ok;
    logic [WIDTH-1:0] w_value_plus1;
    logic [WIDTH-1:0] w_expected_plus1;
    logic [ERR_W-1:0] w_err_count;

    assign w_hit            = (bus.ivalue == r_expected);
    assign w_value_plus1    = bus.ivalue + WIDTH'(1);
    assign w_expected_plus1 = r_expected + WIDTH'(1);

`ifdef COUNTER_CHECKER_RESTART_EN
    assign w_restart_ok = (bus.ivalue == '0);
`else
    assign w_restart_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state     <= IDLE;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_error     <= 1'b0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_expected  <= w_expected_next;
            r_match_cnt <= w_match_next;
            r_error     <= w_error_next;
            r_restart   <= w_restart_next;
        end
    end

    // Next-state logic; with ivalid low everything holds and pulses drop.
    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_match_next    = r_match_cnt;
        w_error_next    = 1'b0;
        w_restart_next  = 1'b0;

        if (bus.ivalid) begin
            case (r_state)
                IDLE: begin
                    w_expected_next = w_value_plus1;
                    w_match_next    = '0;
                    w_state_next    = ACQ;
                end
                ACQ: begin
                    if (w_hit) begin
                        w_expected_next = w_expected_plus1;
                        if ((r_match_cnt + 4'd1) == LOCK_TARGET) begin
                            w_state_next = LOCKED;
                            w_match_next = '0;
                        end else begin
                            w_match_next = r_match_cnt + 4'd1;
                        end
                    end else begin
                        // Not yet trusted: silently re-seed from this sample.
                        w_expected_next = w_value_plus1;
                        w_match_next    = '0;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_expected_next = w_expected_plus1;
                    end else if (w_restart_ok) begin
                        w_restart_next  = 1'b1;
                        w_expected_next = WIDTH'(1);
                    end else begin
                        w_error_next    = 1'b1;
                        w_expected_next = w_value_plus1;
                        w_match_next    = '0;
                        w_state_next    = ACQ;
                    end
                end
                default: begin
                    w_state_next    = IDLE;
                    w_expected_next = '0;
                    w_match_next    = '0;
                end
            endcase
        end
    end

    // The tally increments on the same edge that raises oerror, so both
    // become visible together.
    sat_counter #(
        .W (ERR_W)
    ) u_err_count (
        .i_clk   (iclk),
        .i_clr_n (ireset),
        .i_en    (w_error_next),
        .o_count (w_err_count)
    );

    assign bus.olocked    = (r_state == LOCKED);
    assign bus.oerror     = r_error;
    assign bus.orestart   = r_restart;
    assign bus.oerr_count = w_err_count;
    assign bus.oexpected  = r_expected;
endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
// Scoreboard bench for counter_checker (WIDTH=8, LOCK_CNT=3, ERR_W=2).
// The driver applies one directed vector per cycle and pushes the
// hand-computed response; the monitor pops and compares one entry after each
// rising edge. Rows that depend on COUNTER_CHECKER_RESTART_EN are selected
// with the same macro.
// -----------------------------------------------------------------------------
module tb_counter_checker;

    logic iclk;
    logic ireset;

    typedef struct {
        string      name;
        logic       l;
        logic       e;
        logic       r;
        logic [1:0] c;
        logic [7:0] x;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;

    counter_checker_if #(.WIDTH(8), .ERR_W(2)) bus_if ();

    counter_checker #(
        .WIDTH    (8),
        .LOCK_CNT (3),
        .ERR_W    (2)
    ) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus_if.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    endtask

    // One transaction: apply a sample and record its expected response.
    task automatic drive(input string name, input bit v, input logic [7:0] val,
                         input bit l, input bit e, input bit r,
                         input logic [1:0] c, input logic [7:0] x);
        exp_t t;
        @(negedge iclk);
        #1;
        bus_if.ivalid = v;
        bus_if.ivalue = val;
        t.name = name; t.l = l; t.e = e; t.r = r; t.c = c; t.x = x;
        sb_q.push_back(t);
        $display("drive %-10s valid=%0d value=0x%02h", name, v, val);
    endtask

    // Monitor: every output cycle produces one response, checked 1 ns after
    // the edge that produced it.
    initial begin
        exp_t t;
        forever begin
            @(posedge iclk);
            #1;
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                chk({t.name, ".locked"},  int'(bus_if.olocked),    int'(t.l));
                chk({t.name, ".error"},   int'(bus_if.oerror),     int'(t.e));
                chk({t.name, ".restart"}, int'(bus_if.orestart),   int'(t.r));
                chk({t.name, ".count"},   int'(bus_if.oerr_count), int'(t.c));
                chk({t.name, ".expect"},  int'(bus_if.oexpected),  int'(t.x));
                $display("check %-10s locked=%0d err=%0d rst=%0d cnt=%0d exp=0x%02h",
                         t.name, bus_if.olocked, bus_if.oerror, bus_if.orestart,
                         bus_if.oerr_count, bus_if.oexpected);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, ".locked"},  int'(bus_if.olocked),    0);
        chk({tag, ".error"},   int'(bus_if.oerror),     0);
        chk({tag, ".restart"}, int'(bus_if.orestart),   0);
        chk({tag, ".count"},   int'(bus_if.oerr_count), 0);
        chk({tag, ".expect"},  int'(bus_if.oexpected),  0);
        chk({tag, ".state"},   int'(dut.r_state),       0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ireset        = 1'b1;
        bus_if.ivalid = 1'b0;
        bus_if.ivalue = 8'h00;
        #1 ireset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge iclk);
        ireset = 1'b1;

        // Clean stream: lock after three correct increments
        drive("clean0",  1, 8'h10, 0, 0, 0, 2'd0, 8'h11);
        drive("clean1",  1, 8'h11, 0, 0, 0, 2'd0, 8'h12);
        drive("clean2",  1, 8'h12, 0, 0, 0, 2'd0, 8'h13);
        drive("clean3",  1, 8'h13, 1, 0, 0, 2'd0, 8'h14);
        drive("lockrun", 1, 8'h14, 1, 0, 0, 2'd0, 8'h15);
        // Break while locked, then relock
        drive("break1",  1, 8'h25, 0, 1, 0, 2'd1, 8'h26);
        drive("relock0", 1, 8'h26, 0, 0, 0, 2'd1, 8'h27);
        drive("relock1", 1, 8'h27, 0, 0, 0, 2'd1, 8'h28);
        drive("relock2", 1, 8'h28, 1, 0, 0, 2'd1, 8'h29);
        // Gap: ivalid low holds everything (ivalue is ignored)
        for (int i = 0; i < 5; i++)
            drive("gap", 0, 8'h77, 1, 0, 0, 2'd1, 8'h29);
        drive("aftergap", 1, 8'h29, 1, 0, 0, 2'd1, 8'h2A);
        // Held value is a break
        drive("hold",    1, 8'h29, 0, 1, 0, 2'd2, 8'h2A);
        drive("acq_a",   1, 8'h2A, 0, 0, 0, 2'd2, 8'h2B);
        drive("acq_b",   1, 8'h2B, 0, 0, 0, 2'd2, 8'h2C);
        drive("acq_c",   1, 8'h2C, 1, 0, 0, 2'd2, 8'h2D);
        // Wrap through 0xFF -> 0x00
        drive("break3",  1, 8'hFD, 0, 1, 0, 2'd3, 8'hFE);
        drive("wrapFE",  1, 8'hFE, 0, 0, 0, 2'd3, 8'hFF);
        drive("wrapFF",  1, 8'hFF, 0, 0, 0, 2'd3, 8'h00);
        drive("wrap00",  1, 8'h00, 1, 0, 0, 2'd3, 8'h01);
        drive("wrap01",  1, 8'h01, 1, 0, 0, 2'd3, 8'h02);
`ifdef COUNTER_CHECKER_RESTART_EN
        drive("restart", 1, 8'h00, 1, 0, 1, 2'd3, 8'h01);
        drive("rs_next", 1, 8'h01, 1, 0, 0, 2'd3, 8'h02);
        drive("break5",  1, 8'h50, 0, 1, 0, 2'd3, 8'h51);
`else
        drive("restart", 1, 8'h00, 0, 1, 0, 2'd3, 8'h01);
        drive("rs_next", 1, 8'h01, 0, 0, 0, 2'd3, 8'h02);
        drive("recap50", 1, 8'h50, 0, 0, 0, 2'd3, 8'h51);
`endif
        drive("acq51",   1, 8'h51, 0, 0, 0, 2'd3, 8'h52);
        drive("acq52",   1, 8'h52, 0, 0, 0, 2'd3, 8'h53);
        drive("acq53",   1, 8'h53, 1, 0, 0, 2'd3, 8'h54);
        drive("sat",     1, 8'h60, 0, 1, 0, 2'd3, 8'h61);
        drive("pre_rst", 1, 8'h61, 0, 0, 0, 2'd3, 8'h62);

        // Asynchronous reset mid-cycle: outputs must clear before any edge
        @(negedge iclk);
        #1 bus_if.ivalid = 1'b0;
        @(posedge iclk);
        #3;
        chk("queue_pre_rst", sb_q.size(), 0);
        ireset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge iclk);
        ireset = 1'b1;

        drive("post0", 1, 8'h05, 0, 0, 0, 2'd0, 8'h06);
        drive("post1", 1, 8'h06, 0, 0, 0, 2'd0, 8'h07);

        @(negedge iclk);
        #1 bus_if.ivalid = 1'b0;
        repeat (3) @(posedge iclk);
        #2;
        chk("queue_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
